// File: rtl/fm_bus_arbiter_pkg.sv
// Shared definitions for the F-bus / M-bus to X-bus arbiter: grant states and lane selects.
// Also used by the optional fetch buffer (FM_FETCH_BUFFER_EN).
package fm_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_F = 2'd1,
        ST_GNT_M = 2'd2
    } state_e;

    localparam logic [7:0] SEL_LO = 8'h0F;
    localparam logic [7:0] SEL_HI = 8'hF0;

    // Picks the 32-bit instruction word out of a 64-bit dword.
    function automatic logic [31:0] lane_sel(input logic [63:0] dword, input logic hi);
        return hi ? dword[63:32] : dword[31:0];
    endfunction

endpackage

// File: rtl/fm_fetch_buffer.sv
// One-entry dword fetch buffer: remembers the last X-bus fetch beat and answers repeat fetches.
// Only instantiated when FM_FETCH_BUFFER_EN is defined.
module fm_fetch_buffer
    import fm_bus_arbiter_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        load_i,
    input  logic [63:3] load_tag_i,
    input  logic [63:0] load_data_i,
    input  logic        inval_i,
    input  logic [63:3] inval_tag_i,
    input  logic [63:3] lookup_tag_i,
    input  logic        lookup_hi_i,
    output logic        hit_o,
    output logic [31:0] hit_word_o
);

    logic        valid_q, valid_d;
    logic [63:3] tag_q, tag_d;
    logic [63:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            tag_d   = load_tag_i;
            data_d  = load_data_i;
        end else if (inval_i && (inval_tag_i == tag_q)) begin
            // A write to the buffered dword makes the copy stale.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign hit_o      = valid_q && (tag_q == lookup_tag_i);
    assign hit_word_o = lane_sel(data_q, lookup_hi_i);

endmodule

// File: rtl/fm_bus_arbiter.sv
// Shares the 64-bit X-bus between the 32-bit fetch bus and the 64-bit data bus, one beat at a
// time. Defining FM_FETCH_BUFFER_EN adds a one-entry fetch buffer that serves repeat fetches.
module fm_bus_arbiter
    import fm_bus_arbiter_pkg::*;
#(
    parameter bit M_FIRST = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        f_cyc_i,
    input  logic [63:2] f_adr_i,
    output logic        f_ack_o,
    output logic [31:0] f_dat_o,
    input  logic        m_cyc_i,
    input  logic        m_we_i,
    input  logic [7:0]  m_sel_i,
    input  logic [63:3] m_adr_i,
    input  logic [63:0] m_dat_i,
    output logic        m_ack_o,
    output logic [63:0] m_dat_o,
    output logic        x_cyc_o,
    output logic        x_we_o,
    output logic [7:0]  x_sel_o,
    output logic [63:3] x_adr_o,
    output logic [63:0] x_dat_o,
    input  logic        x_ack_i,
    input  logic [63:0] x_dat_i
);

    state_e      state_q, state_d;
    logic        buf_hit;
    logic [31:0] buf_word;
    logic        f_req;

`ifdef FM_FETCH_BUFFER_EN
    logic buf_match;

    fm_fetch_buffer u_fetch_buffer (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .load_i       ((state_q == ST_GNT_F) && !buf_hit && x_ack_i && !reset_i),
        .load_tag_i   (f_adr_i[63:3]),
        .load_data_i  (x_dat_i),
        .inval_i      ((state_q == ST_GNT_M) && m_we_i && x_ack_i && !reset_i),
        .inval_tag_i  (m_adr_i),
        .lookup_tag_i (f_adr_i[63:3]),
        .lookup_hi_i  (f_adr_i[2]),
        .hit_o        (buf_match),
        .hit_word_o   (buf_word)
    );

    assign buf_hit = f_cyc_i && buf_match;
`else
    assign buf_hit  = 1'b0;
    assign buf_word = '0;
`endif

    // A fetch served by the buffer never needs the X-bus.
    assign f_req = f_cyc_i && !buf_hit;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (f_req && m_cyc_i) begin
                    state_d = M_FIRST ? ST_GNT_M : ST_GNT_F;
                end else if (f_req) begin
                    state_d = ST_GNT_F;
                end else if (m_cyc_i) begin
                    state_d = ST_GNT_M;
                end
            end
            ST_GNT_F: begin
                if (buf_hit) begin
                    state_d = m_cyc_i ? ST_GNT_M : ST_GNT_F;
                end else if (x_ack_i) begin
                    state_d = m_cyc_i ? ST_GNT_M : (f_cyc_i ? ST_GNT_F : ST_IDLE);
                end else if (!f_cyc_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GNT_M: begin
                // m_cyc_i during the ack belongs to the finished beat, so M is not regranted.
                if (x_ack_i) begin
                    state_d = f_cyc_i ? ST_GNT_F : ST_IDLE;
                end else if (!m_cyc_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        x_cyc_o = 1'b0;
        x_we_o  = 1'b0;
        x_sel_o = '0;
        x_adr_o = f_adr_i[63:3];
        x_dat_o = '0;
        f_ack_o = 1'b0;
        m_ack_o = 1'b0;
        f_dat_o = buf_hit ? buf_word : lane_sel(x_dat_i, f_adr_i[2]);
        m_dat_o = x_dat_i;
        if (!reset_i) begin
            unique case (state_q)
                ST_IDLE: begin
                    f_ack_o = buf_hit;
                end
                ST_GNT_F: begin
                    if (buf_hit) begin
                        f_ack_o = 1'b1;
                    end else begin
                        x_cyc_o = f_cyc_i;
                        x_sel_o = f_adr_i[2] ? SEL_HI : SEL_LO;
                        f_ack_o = x_ack_i;
                    end
                end
                ST_GNT_M: begin
                    x_cyc_o = m_cyc_i;
                    x_we_o  = m_we_i;
                    x_sel_o = m_sel_i;
                    x_adr_o = m_adr_i;
                    x_dat_o = m_dat_i;
                    m_ack_o = x_ack_i;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fm_bus_arbiter.sv
// Self-checking bench for fm_bus_arbiter: directed scenarios plus a randomized run against an
// owner-tracking reference model. The fetch buffer scenario runs when FM_FETCH_BUFFER_EN is set.
module tb_fm_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, f_cyc, m_cyc, m_we, x_ack;
    logic [63:2] f_adr;
    logic [7:0]  m_sel;
    logic [63:3] m_adr;
    logic [63:0] m_dat, x_rdat;

    logic        f_ack, m_ack, x_cyc, x_we;
    logic [31:0] f_dat;
    logic [63:0] m_rdat, x_wdat;
    logic [7:0]  x_sel;
    logic [63:3] x_adr;

    logic        d0_f_ack, d0_m_ack, d0_x_cyc, d0_x_we;
    logic [31:0] d0_f_dat;
    logic [63:0] d0_m_rdat, d0_x_wdat;
    logic [7:0]  d0_x_sel;
    logic [63:3] d0_x_adr;

    int checks = 0;
    int errors = 0;

    fm_bus_arbiter #(.M_FIRST(1'b1)) u_dut (
        .clk_i(clk), .reset_i(rst), .f_cyc_i(f_cyc), .f_adr_i(f_adr), .f_ack_o(f_ack),
        .f_dat_o(f_dat), .m_cyc_i(m_cyc), .m_we_i(m_we), .m_sel_i(m_sel), .m_adr_i(m_adr),
        .m_dat_i(m_dat), .m_ack_o(m_ack), .m_dat_o(m_rdat), .x_cyc_o(x_cyc), .x_we_o(x_we),
        .x_sel_o(x_sel), .x_adr_o(x_adr), .x_dat_o(x_wdat), .x_ack_i(x_ack), .x_dat_i(x_rdat)
    );

    fm_bus_arbiter #(.M_FIRST(1'b0)) u_dut_f_first (
        .clk_i(clk), .reset_i(rst), .f_cyc_i(f_cyc), .f_adr_i(f_adr), .f_ack_o(d0_f_ack),
        .f_dat_o(d0_f_dat), .m_cyc_i(m_cyc), .m_we_i(m_we), .m_sel_i(m_sel), .m_adr_i(m_adr),
        .m_dat_i(m_dat), .m_ack_o(d0_m_ack), .m_dat_o(d0_m_rdat), .x_cyc_o(d0_x_cyc),
        .x_we_o(d0_x_we), .x_sel_o(d0_x_sel), .x_adr_o(d0_x_adr), .x_dat_o(d0_x_wdat),
        .x_ack_i(x_ack), .x_dat_i(x_rdat)
    );

    task automatic do_reset();
        rst = 1'b1; f_cyc = 1'b0; m_cyc = 1'b0; m_we = 1'b0; x_ack = 1'b0;
        f_adr = '0; m_sel = '0; m_adr = '0; m_dat = '0; x_rdat = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; f_cyc = 1'b1; m_cyc = 1'b1; m_we = 1'b1; m_sel = 8'hFF; x_ack = 1'b1;
        f_adr = '0; m_adr = '0; m_dat = '0; x_rdat = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({x_cyc, x_we, f_ack, m_ack} !== 4'b0)
            begin errors++; $display("FAIL rst_ctrl got=%b want=0000", {x_cyc, x_we, f_ack, m_ack}); end
        checks++;
        if (x_sel !== 8'h00) begin errors++; $display("FAIL rst_sel got=%h want=00", x_sel); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (x_cyc !== 1'b0) begin errors++; $display("FAIL rst_idle got=%b want=0", x_cyc); end
        do_reset();
    endtask

    localparam logic [63:2] FBase = 62'h3FFF_FFFF_FFFF_FFC0;

    task automatic test_fetch_stream();
        logic [63:2] a;
        do_reset();
        f_cyc = 1'b1; f_adr = FBase; x_ack = 1'b1;
        #1;
        checks++;
        if (x_cyc !== 1'b0) begin errors++; $display("FAIL fs_latency got=%b want=0", x_cyc); end
        // Stride of three words covers both lanes without revisiting a dword.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a = FBase + 62'(3 * i);
            f_adr = a;
            x_rdat = {$urandom, $urandom};
            #1;
            checks++;
            if ({x_cyc, f_ack, x_we} !== 3'b110)
                begin errors++; $display("FAIL fs_ctrl%0d got=%b want=110", i, {x_cyc, f_ack, x_we}); end
            checks++;
            if (x_sel !== (a[2] ? 8'hF0 : 8'h0F))
                begin errors++; $display("FAIL fs_sel%0d got=%h want=%h", i, x_sel, a[2] ? 8'hF0 : 8'h0F); end
            checks++;
            if (x_adr !== a[63:3]) begin errors++; $display("FAIL fs_adr%0d got=%h want=%h", i, x_adr, a[63:3]); end
            checks++;
            if (f_dat !== (a[2] ? x_rdat[63:32] : x_rdat[31:0]))
                begin errors++; $display("FAIL fs_dat%0d got=%h", i, f_dat); end
        end
    endtask

    // Runs straight after test_fetch_stream, with F still owning the bus.
    task automatic test_m_interleave();
        logic [63:2] a;
        @(negedge clk);
        f_adr = FBase + 62'd18;
        m_cyc = 1'b1; m_we = 1'b1; m_sel = 8'hFF; m_adr = 61'h100; m_dat = 64'hDEAD_BEEF_0123_4567;
        #1;
        checks++;
        if ({f_ack, m_ack, x_we} !== 3'b100)
            begin errors++; $display("FAIL mi_fbeat got=%b want=100", {f_ack, m_ack, x_we}); end
        @(negedge clk);
        #1;
        checks++;
        if ({x_cyc, x_we, m_ack, f_ack} !== 4'b1110)
            begin errors++; $display("FAIL mi_mctrl got=%b want=1110", {x_cyc, x_we, m_ack, f_ack}); end
        checks++;
        if ({x_sel, x_adr, x_wdat} !== {8'hFF, 61'h100, 64'hDEAD_BEEF_0123_4567})
            begin errors++; $display("FAIL mi_mbus got=%h/%h/%h", x_sel, x_adr, x_wdat); end
        @(negedge clk);
        m_cyc = 1'b0; m_we = 1'b0;
        a = FBase + 62'd21;
        f_adr = a;
        #1;
        checks++;
        if ({x_cyc, x_we, f_ack, m_ack} !== 4'b1010)
            begin errors++; $display("FAIL mi_fresume got=%b want=1010", {x_cyc, x_we, f_ack, m_ack}); end
        checks++;
        if ({x_adr, x_wdat} !== {a[63:3], 64'h0})
            begin errors++; $display("FAIL mi_fadr got=%h/%h want=%h/0", x_adr, x_wdat, a[63:3]); end
    endtask

    task automatic test_tie_break();
        logic m_turn;
        do_reset();
        f_cyc = 1'b1; m_cyc = 1'b1; m_we = 1'b0; m_sel = 8'hA5; x_ack = 1'b1;
        #1;
        checks++;
        if ({x_cyc, d0_x_cyc} !== 2'b00) begin errors++; $display("FAIL tb_idle got=%b want=00", {x_cyc, d0_x_cyc}); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            f_adr = 62'({$urandom, $urandom});
            m_adr = 61'({$urandom, $urandom});
            m_dat = {$urandom, $urandom};
            x_rdat = {$urandom, $urandom};
            #1;
            m_turn = (i % 2 == 0);
            checks++;
            if ({m_ack, f_ack} !== {m_turn, !m_turn})
                begin errors++; $display("FAIL tb_mfirst%0d got=%b want=%b", i, {m_ack, f_ack}, {m_turn, !m_turn}); end
            checks++;
            if ({d0_m_ack, d0_f_ack} !== {!m_turn, m_turn})
                begin errors++; $display("FAIL tb_ffirst%0d got=%b want=%b", i, {d0_m_ack, d0_f_ack}, {!m_turn, m_turn}); end
            checks++;
            if (m_turn) begin
                if ({d0_x_we, d0_x_sel, d0_x_adr, d0_x_wdat, d0_f_dat}
                        !== {1'b0, (f_adr[2] ? 8'hF0 : 8'h0F), f_adr[63:3], 64'h0,
                             (f_adr[2] ? x_rdat[63:32] : x_rdat[31:0])})
                    begin errors++; $display("FAIL tb_ffirst_fbus%0d got=%h/%h/%h", i, d0_x_sel, d0_x_adr, d0_f_dat); end
            end else begin
                if ({d0_x_we, d0_x_sel, d0_x_adr, d0_x_wdat, d0_m_rdat}
                        !== {1'b0, 8'hA5, m_adr, m_dat, x_rdat})
                    begin errors++; $display("FAIL tb_ffirst_mbus%0d got=%h/%h/%h", i, d0_x_sel, d0_x_adr, d0_x_wdat); end
            end
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        f_cyc = 1'b1; f_adr = 62'h0000_0000_0000_1235; x_ack = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({x_cyc, f_ack, x_adr} !== {2'b10, 61'h91A})
                begin errors++; $display("FAIL ws_wait%0d got=%b%b/%h want=10/91a", i, x_cyc, f_ack, x_adr); end
        end
        @(negedge clk);
        x_ack = 1'b1; x_rdat = 64'h1111_2222_3333_4444;
        #1;
        checks++;
        if ({f_ack, x_sel, f_dat} !== {1'b1, 8'hF0, 32'h1111_2222})
            begin errors++; $display("FAIL ws_ack got=%b/%h/%h want=1/f0/11112222", f_ack, x_sel, f_dat); end
    endtask

    task automatic test_reset_mid_m();
        do_reset();
        m_cyc = 1'b1; m_we = 1'b1; m_sel = 8'h3C; m_adr = 61'h55; m_dat = 64'h0123; x_ack = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (x_cyc !== 1'b1) begin errors++; $display("FAIL rm_grant got=%b want=1", x_cyc); end
        @(negedge clk);
        rst = 1'b1; x_ack = 1'b1;
        #1;
        checks++;
        if ({m_ack, x_cyc, x_we} !== 3'b000)
            begin errors++; $display("FAIL rm_ackdrop got=%b want=000", {m_ack, x_cyc, x_we}); end
        @(negedge clk);
        rst = 1'b0; x_ack = 1'b0;
        #1;
        checks++;
        if (x_cyc !== 1'b0) begin errors++; $display("FAIL rm_idle got=%b want=0", x_cyc); end
        @(negedge clk);
        #1;
        checks++;
        if (x_cyc !== 1'b1) begin errors++; $display("FAIL rm_regrant got=%b want=1", x_cyc); end
    endtask

`ifdef FM_FETCH_BUFFER_EN
    task automatic test_fetch_buffer();
        logic [63:2] a;
        do_reset();
        a = 62'h40;
        f_cyc = 1'b1; f_adr = a; x_ack = 1'b1; x_rdat = 64'hCAFE_F00D_1234_5678;
        #1;
        @(negedge clk);
        #1;
        checks++;
        if ({x_cyc, f_ack} !== 2'b11) begin errors++; $display("FAIL fb_miss got=%b want=11", {x_cyc, f_ack}); end
        @(negedge clk);
        f_adr = a + 62'd1; x_ack = 1'b0; x_rdat = '0;
        m_cyc = 1'b1; m_we = 1'b1; m_sel = 8'hFF; m_adr = a[63:3]; m_dat = 64'h5;
        #1;
        checks++;
        if ({x_cyc, f_ack, f_dat} !== {2'b01, 32'hCAFE_F00D})
            begin errors++; $display("FAIL fb_hit got=%b%b/%h want=01/cafef00d", x_cyc, f_ack, f_dat); end
        @(negedge clk);
        x_ack = 1'b1;
        #1;
        checks++;
        if ({m_ack, f_ack} !== 2'b10) begin errors++; $display("FAIL fb_mwrite got=%b want=10", {m_ack, f_ack}); end
        @(negedge clk);
        m_cyc = 1'b0; m_we = 1'b0; x_ack = 1'b0;
        #1;
        checks++;
        if ({x_cyc, f_ack} !== 2'b10) begin errors++; $display("FAIL fb_inval got=%b want=10", {x_cyc, f_ack}); end
    endtask
`endif

    // Reference model: tracks who holds the X-bus ("N" nobody, "F" fetch, "M" data).
    task automatic test_random();
        byte         owner, nxt;
        logic        e_cyc, e_we, e_fack, e_mack;
        logic [7:0]  e_sel;
        logic [63:3] e_adr;
        logic [63:0] e_wdat;
        do_reset();
        owner = "N";
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 39) == 0);
            f_cyc = ($urandom_range(0, 3) != 0);
            m_cyc = ($urandom_range(0, 2) == 0);
            m_we = 1'($urandom); m_sel = 8'($urandom);
            x_ack = ($urandom_range(0, 2) != 0);
            f_adr = 62'({$urandom, $urandom});
            m_adr = 61'({$urandom, $urandom});
            m_dat = {$urandom, $urandom};
            x_rdat = {$urandom, $urandom};
            #1;
            e_cyc = 1'b0; e_we = 1'b0; e_fack = 1'b0; e_mack = 1'b0;
            e_sel = 8'h00; e_adr = '0; e_wdat = '0; nxt = "N";
            if (!rst) begin
                if (owner == "N") begin
                    if (f_cyc && m_cyc) nxt = "M";
                    else if (f_cyc) nxt = "F";
                    else if (m_cyc) nxt = "M";
                end else if (owner == "F") begin
                    e_cyc = f_cyc; e_fack = x_ack; e_adr = f_adr[63:3];
                    e_sel = f_adr[2] ? 8'hF0 : 8'h0F;
                    if (x_ack) nxt = m_cyc ? "M" : (f_cyc ? "F" : "N");
                    else nxt = f_cyc ? "F" : "N";
                end else begin
                    e_cyc = m_cyc; e_we = m_we; e_sel = m_sel; e_adr = m_adr; e_wdat = m_dat;
                    e_mack = x_ack;
                    if (x_ack) nxt = f_cyc ? "F" : "N";
                    else nxt = m_cyc ? "M" : "N";
                end
            end
            checks++;
            if ({x_cyc, x_we, f_ack, m_ack} !== {e_cyc, e_we, e_fack, e_mack})
                begin errors++; $display("FAIL rnd_ctrl%0d own=%c got=%b want=%b", n, owner,
                      {x_cyc, x_we, f_ack, m_ack}, {e_cyc, e_we, e_fack, e_mack}); end
            checks++;
            if (x_sel !== e_sel) begin errors++; $display("FAIL rnd_sel%0d got=%h want=%h", n, x_sel, e_sel); end
            if (!rst) begin
                checks++;
                if (x_wdat !== e_wdat) begin errors++; $display("FAIL rnd_wdat%0d got=%h want=%h", n, x_wdat, e_wdat); end
                if (owner != "N") begin
                    checks++;
                    if (x_adr !== e_adr) begin errors++; $display("FAIL rnd_adr%0d got=%h want=%h", n, x_adr, e_adr); end
                end
            end
            if (e_fack) begin
                checks++;
                if (f_dat !== (f_adr[2] ? x_rdat[63:32] : x_rdat[31:0]))
                    begin errors++; $display("FAIL rnd_fdat%0d got=%h", n, f_dat); end
            end
            if (e_mack) begin
                checks++;
                if (m_rdat !== x_rdat) begin errors++; $display("FAIL rnd_mdat%0d got=%h want=%h", n, m_rdat, x_rdat); end
            end
            owner = nxt;
        end
        rst = 1'b0; f_cyc = 1'b0; m_cyc = 1'b0; x_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch_stream();
        test_m_interleave();
        test_tie_break();
        test_wait_states();
        test_reset_mid_m();
`ifdef FM_FETCH_BUFFER_EN
        test_fetch_buffer();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
